rx_frame_ctrl: RTL and testbench



---
 rtl/rx_frame_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// Frame-level receive controller: buffers one Manchester-receiver frame, qualifies it
// (runt / overflow / error) and streams good frames out over valid/ready. Optional macro: RX_TIMEOUT_EN.
module rx_frame_ctrl #(
   parameter int DEPTH          = 32,
   parameter int MIN_LEN        = 1,
   parameter int MAX_LEN        = 32,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [7:0]                     rx_data,
   input  logic                           rx_write,
   input  logic                           rx_cardet,
   input  logic                           rx_error,
   output logic [7:0]                     rd_data,
   output logic                           rd_valid,
   input  logic                           rd_ready,
   output logic                           rd_last,
   output logic                           frame_ready,
   output logic [$clog2(DEPTH+1)-1:0]     frame_len,
   output logic                           drop,
   output logic [7:0]                     drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam bit CFG_OK = (MIN_LEN <= MAX_LEN) && (MAX_LEN <= DEPTH) && (TIMEOUT_CYCLES > 0);
   // A misconfigured MAX_LEN is clamped to the buffer size so writes can never wrap.
   localparam logic [LW-1:0] MAX_L = CFG_OK ? LW'(MAX_LEN) : LW'(DEPTH);
   localparam logic [LW-1:0] MIN_L = LW'(MIN_LEN);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RECV    = 3'd1,
      DISCARD = 3'd2,
      HOLD    = 3'd3,
      DRAIN   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic            cardet_q;
   logic [LW-1:0]   wr_cnt_q, wr_cnt_d;
   logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            frame_ready_q, frame_ready_d;
   logic [LW-1:0]   frame_len_q, frame_len_d;
   logic            drop_q, drop_d;
   logic [7:0]      drop_count_q, drop_count_d;
   logic            mem_we_s;
   logic [LW-1:0]   wr_next_s;
   logic            cardet_rise_s, cardet_fall_s;
   logic            timeout_s;
   logic            rd_last_s;
   logic [7:0]      mem_q [DEPTH];

   assign cardet_rise_s = rx_cardet & ~cardet_q;
   assign cardet_fall_s = ~rx_cardet & cardet_q;

`ifdef RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_q, tmo_d;

   // Inter-byte watchdog: held at zero outside RECV, so it restarts on every RECV entry.
   always_comb begin
      tmo_d = tmo_q;
      if ((state_q != RECV) || rx_write) begin
         tmo_d = '0;
      end else if (tmo_q != TMO_LAST) begin
         tmo_d = tmo_q + TW'(1);
      end else begin
         tmo_d = tmo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign timeout_s = (state_q == RECV) && rx_cardet && !rx_write && (tmo_q == TMO_LAST);
`else
   assign timeout_s = 1'b0;
`endif

   assign rd_last_s = (state_q == DRAIN) && ((rd_ptr_q + LW'(1)) == frame_len_q);

   // Next-state and frame bookkeeping.
   always_comb begin
      state_d       = state_q;
      wr_cnt_d      = wr_cnt_q;
      rd_ptr_d      = rd_ptr_q;
      frame_ready_d = frame_ready_q;
      frame_len_d   = frame_len_q;
      drop_d        = 1'b0;
      drop_count_d  = drop_count_q;
      mem_we_s      = 1'b0;
      wr_next_s     = wr_cnt_q;

      case (state_q)
         IDLE: begin
            if (cardet_rise_s) begin
               state_d  = RECV;
               wr_cnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RECV: begin
            if (rx_error) begin
               state_d = DISCARD;
               drop_d  = 1'b1;
            end else if (rx_write && (wr_cnt_q == MAX_L)) begin
               state_d = DISCARD;
               drop_d  = 1'b1;
            end else begin
               if (rx_write) begin
                  mem_we_s  = 1'b1;
                  wr_next_s = wr_cnt_q + LW'(1);
               end else begin
                  wr_next_s = wr_cnt_q;
               end
               wr_cnt_d = wr_next_s;
               // A byte arriving with the carrier fall still belongs to the frame.
               if (cardet_fall_s) begin
                  if (wr_next_s >= MIN_L) begin
                     state_d       = HOLD;
                     frame_ready_d = 1'b1;
                     frame_len_d   = wr_next_s;
                  end else begin
                     state_d = IDLE;
                     drop_d  = 1'b1;
                  end
               end else if (timeout_s) begin
                  state_d = DISCARD;
                  drop_d  = 1'b1;
               end else begin
                  state_d = RECV;
               end
            end
         end
         DISCARD: begin
            if (!rx_cardet) begin
               state_d = IDLE;
            end else begin
               state_d = DISCARD;
            end
         end
         HOLD: begin
            state_d  = DRAIN;
            rd_ptr_d = '0;
            if (cardet_rise_s) begin
               drop_d = 1'b1;
            end else begin
               drop_d = 1'b0;
            end
         end
         DRAIN: begin
            if (cardet_rise_s) begin
               drop_d = 1'b1;
            end else begin
               drop_d = 1'b0;
            end
            if (rd_ready && rd_last_s) begin
               state_d       = IDLE;
               frame_ready_d = 1'b0;
               rd_ptr_d      = '0;
            end else if (rd_ready) begin
               rd_ptr_d = rd_ptr_q + LW'(1);
            end else begin
               rd_ptr_d = rd_ptr_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (drop_d && (drop_count_q != 8'hFF)) begin
         drop_count_d = drop_count_q + 8'd1;
      end else begin
         drop_count_d = drop_count_q;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cardet_q      <= 1'b1;
         wr_cnt_q      <= '0;
         rd_ptr_q      <= '0;
         frame_ready_q <= 1'b0;
         frame_len_q   <= '0;
         drop_q        <= 1'b0;
         drop_count_q  <= 8'd0;
      end else begin
         state_q       <= state_d;
         cardet_q      <= rx_cardet;
         wr_cnt_q      <= wr_cnt_d;
         rd_ptr_q      <= rd_ptr_d;
         frame_ready_q <= frame_ready_d;
         frame_len_q   <= frame_len_d;
         drop_q        <= drop_d;
         drop_count_q  <= drop_count_d;
      end
   end

   // Frame buffer; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[wr_cnt_q[AW-1:0]] <= rx_data;
      end
   end

   assign rd_valid    = (state_q == DRAIN);
   assign rd_data     = (state_q == DRAIN) ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
   assign rd_last     = rd_last_s;
   assign frame_ready = frame_ready_q;
   assign frame_len   = frame_len_q;
   assign drop        = drop_q;
   assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: directed frames from the test plan plus
// randomized frames checked against a frame-level outcome model.
module tb_rx_frame_ctrl;

   localparam int DEPTH          = 8;
   localparam int MIN_LEN        = 2;
   localparam int MAX_LEN        = 4;
   localparam int TIMEOUT_CYCLES = 100;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_write;
   logic       rx_cardet;
   logic       rx_error;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic       rd_last;
   logic       frame_ready;
   logic [3:0] frame_len;
   logic       drop;
   logic [7:0] drop_count;

   int n_checks   = 0;
   int n_fail     = 0;
   int exp_count  = 0;
   int exp_pulses = 0;
   int drop_pulses = 0;

   rx_frame_ctrl #(
      .DEPTH(DEPTH), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_write(rx_write), .rx_cardet(rx_cardet),
      .rx_error(rx_error), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_last(rd_last), .frame_ready(frame_ready), .frame_len(frame_len), .drop(drop),
      .drop_count(drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (!rst && drop) drop_pulses++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
      check({tag, "_rd_last"},     32'(rd_last),     32'd0);
      check({tag, "_rd_data"},     32'(rd_data),     32'd0);
      check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
      check({tag, "_frame_len"},   32'(frame_len),   32'd0);
      check({tag, "_drop"},        32'(drop),        32'd0);
      check({tag, "_drop_count"},  32'(drop_count),  32'd0);
   endtask

   task automatic send_frame(input logic [7:0] bytes[$], input int err_idx, input int gap,
                             input bit same_cycle);
      int n;
      n = bytes.size();
      rx_cardet = 1'b0;
      step();
      rx_cardet = 1'b1;
      step();
      for (int i = 0; i < n; i++) begin
         rx_write = 1'b1;
         rx_data  = bytes[i];
         rx_error = (i == err_idx);
         if (same_cycle && (i == n - 1)) rx_cardet = 1'b0;
         step();
         rx_write = 1'b0;
         rx_error = 1'b0;
         rx_data  = 8'($urandom);
         if (!(same_cycle && (i == n - 1))) repeat (gap) step();
      end
      if (!(same_cycle && (n > 0))) begin
         rx_cardet = 1'b0;
         step();
      end
   endtask

   // Consumes the held frame with random or stalled ready; an optional carrier pulse during the stall.
   task automatic drain(input logic [7:0] exp[$], input int stall_at, input bit busy);
      int k;
      int budget;
      int stall_left;
      k = 0;
      budget = 0;
      stall_left = (stall_at >= 0) ? 10 : 0;
      while ((k < exp.size()) && (budget < 300)) begin
         budget++;
         if ((k == stall_at) && (stall_left > 0)) begin
            rd_ready = 1'b0;
            stall_left--;
            if (busy && (stall_left == 7)) begin
               rx_cardet = 1'b1;
               exp_count++;
               exp_pulses++;
            end
            if (busy && (stall_left == 4)) rx_cardet = 1'b0;
         end else begin
            rd_ready = ($urandom_range(0, 3) != 0);
         end
         if (rd_valid) begin
            check("rd_data", 32'(rd_data), 32'(exp[k]));
            check("rd_last", 32'(rd_last), 32'(k == exp.size() - 1));
            if (rd_ready) k++;
         end
         step();
      end
      rd_ready  = 1'b0;
      rx_cardet = 1'b0;
      if (k < exp.size()) check("drain_timeout", 32'(k), 32'(exp.size()));
      check("post_drain_valid", 32'(rd_valid), 32'd0);
      check("post_drain_frame_ready", 32'(frame_ready), 32'd0);
      check("post_drain_rd_data", 32'(rd_data), 32'd0);
   endtask

   task automatic run_frame(input logic [7:0] bytes[$], input int err_idx, input int gap,
                            input bit same_cycle, input int stall_at, input bit busy);
      logic [7:0] exp[$];
      bit dropped;
      dropped = 1'b0;
      exp = {};
      for (int i = 0; i < bytes.size(); i++) begin
         if ((i == err_idx) || (i == MAX_LEN)) begin
            dropped = 1'b1;
            break;
         end
         exp.push_back(bytes[i]);
      end
      if (!dropped && (exp.size() < MIN_LEN)) dropped = 1'b1;

      send_frame(bytes, err_idx, gap, same_cycle);
      if (dropped) begin
         exp_count++;
         exp_pulses++;
         check("drop_frame_ready", 32'(frame_ready), 32'd0);
         check("drop_rd_valid", 32'(rd_valid), 32'd0);
         step();
         step();
         check("drop_frame_ready_late", 32'(frame_ready), 32'd0);
      end else begin
         check("frame_ready", 32'(frame_ready), 32'd1);
         check("frame_len", 32'(frame_len), 32'(exp.size()));
         check("hold_rd_valid", 32'(rd_valid), 32'd0);
         drain(exp, stall_at, busy);
      end
      step();
      check("drop_count", 32'(drop_count), 32'(exp_count));
      check("drop_pulses", 32'(drop_pulses), 32'(exp_pulses));
   endtask

   initial begin
      logic [7:0] q[$];
      int len;
      int err_idx;
      int drop_at;

      rst = 1'b1;
      rx_data = 8'h00;
      rx_write = 1'b0;
      rx_cardet = 1'b1;
      rx_error = 1'b0;
      rd_ready = 1'b0;
      repeat (3) step();
      check_reset_outputs("reset");

      // Carrier already high at reset release: that frame must be ignored.
      rst = 1'b0;
      step();
      rx_write = 1'b1;
      rx_data = 8'hA5;
      step();
      rx_data = 8'h5A;
      step();
      rx_write = 1'b0;
      rx_cardet = 1'b0;
      step();
      check("inflight_frame_ready", 32'(frame_ready), 32'd0);
      step();
      step();
      check("inflight_drop_count", 32'(drop_count), 32'd0);
      check("inflight_rd_valid", 32'(rd_valid), 32'd0);

      run_frame('{8'h55, 8'hAA, 8'h0F, 8'hF0}, -1, 0, 1'b0, -1, 1'b0);
      run_frame('{8'h12}, -1, 0, 1'b0, -1, 1'b0);
      run_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, -1, 0, 1'b0, -1, 1'b0);
      run_frame('{8'h11, 8'h22, 8'h33}, 2, 0, 1'b0, -1, 1'b0);
      run_frame('{8'hC1, 8'hC2, 8'hC3}, -1, 1, 1'b0, -1, 1'b0);
      run_frame('{8'hD1, 8'hD2, 8'hD3, 8'hD4}, -1, 0, 1'b0, 1, 1'b1);
      run_frame('{8'hE1, 8'hE2}, -1, 0, 1'b1, -1, 1'b0);
      run_frame('{}, -1, 0, 1'b0, -1, 1'b0);

      // Reset in the middle of draining a frame.
      send_frame('{8'h55, 8'hAA, 8'h0F, 8'hF0}, -1, 0, 1'b0);
      rd_ready = 1'b1;
      step();
      check("mid_rd_data0", 32'(rd_data), 32'h55);
      step();
      check("mid_rd_data1", 32'(rd_data), 32'hAA);
      step();
      check("mid_rd_data2", 32'(rd_data), 32'h0F);
      rst = 1'b1;
      rd_ready = 1'b0;
      step();
      check_reset_outputs("mid_drain_reset");
      rst = 1'b0;
      exp_count = 0;
      step();

      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(0, 6);
         q = {};
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         err_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
         run_frame(q, err_idx, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1,
                   1'($urandom_range(0, 1)));
      end

`ifdef RX_TIMEOUT_EN
      rx_cardet = 1'b0;
      step();
      rx_cardet = 1'b1;
      step();
      drop_at = -1;
      for (int c = 1; c <= 150; c++) begin
         step();
         if (drop && (drop_at < 0)) drop_at = c;
      end
      check("timeout_drop_cycle", 32'(drop_at), 32'd100);
      exp_count++;
      rx_cardet = 1'b0;
      step();
      check("timeout_drop_count", 32'(drop_count), 32'(exp_count));
      check("timeout_frame_ready", 32'(frame_ready), 32'd0);
      rst = 1'b1;
      step();
      check_reset_outputs("timeout_reset");
      rst = 1'b0;
`else
      drop_at = 0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
